// File: rtl/spinv_pkg.sv
// Shared definitions for the speed link between the controller-side
// transmitter and the PWM sine driver's speed receiver.
package spinv_pkg;

    localparam int SPEED_WIDTH = 4;

    typedef enum logic [1:0] {
        st_idle,
        st_setup,
        st_strobe,
        st_gap
    } state_t;

endpackage

// File: rtl/speed_tx_phase_timer.sv
// Loadable down-counter that times one SETUP, STROBE or GAP phase.
// done is high during the last cycle of the loaded duration.
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/speed_tx.sv
// Serializes a parallel speed word MSB-first onto the freq/f_en link;
// the receiver samples freq on each rising edge of f_en.
module speed_tx
    import spinv_pkg::*;
#(
    parameter int WIDTH       = SPEED_WIDTH,
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             freq,
    output logic             f_en
);

    // One timer serves every phase, so it must hold the longer of the two durations.
    localparam int PMAX = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [BW-1:0]    bit_cnt;
    logic             last_bit;
    logic             t_load;
    logic [PW-1:0]    t_val;
    logic             t_done;

    assign tx_ready   = (state == st_idle) && en;
    assign shreg_next = shreg << 1;
    assign last_bit   = (bit_cnt == BW'(WIDTH - 1));

    always_comb begin
        t_load = 1'b0;
        t_val  = PW'(HALF_PERIOD);
        case (state)
            st_idle:   t_load = tx_valid;
            st_setup:  t_load = t_done;
            st_strobe: begin
                t_load = t_done;
                if (last_bit) t_val = PW'(GAP_CYCLES);
            end
            default:   t_load = 1'b0;
        endcase
    end

    phase_timer #(.CW(PW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= st_idle;
            shreg   <= '0;
            bit_cnt <= '0;
            freq    <= 1'b0;
            f_en    <= 1'b0;
            busy    <= 1'b0;
        end else if (en) begin
            case (state)
                st_idle: begin
                    if (tx_valid) begin
                        state   <= st_setup;
                        shreg   <= tx_data;
                        bit_cnt <= '0;
                        freq    <= tx_data[WIDTH-1];
                        f_en    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                st_setup: begin
                    if (t_done) begin
                        state <= st_strobe;
                        f_en  <= 1'b1;
                    end
                end
                st_strobe: begin
                    if (t_done) begin
                        f_en <= 1'b0;
                        if (!last_bit) begin
                            // Next bit appears on freq in the same cycle f_en falls.
                            state   <= st_setup;
                            shreg   <= shreg_next;
                            freq    <= shreg_next[WIDTH-1];
                            bit_cnt <= bit_cnt + BW'(1);
                        end else begin
                            freq <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state <= st_gap;
                            end else begin
                                state <= st_idle;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                st_gap: begin
                    if (t_done) begin
                        state <= st_idle;
                        busy  <= 1'b0;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_tx.sv
// Bench for speed_tx: two instances (gap 4 and gap 0) with a receiver model per link.
module tb_speed_tx;

    localparam int W = 4;
    localparam int H = 2;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         enA = 1'b1, validA = 1'b0;
    logic [W-1:0] dataA = '0;
    logic         readyA, busyA, freqA, fenA;
    logic         enB = 1'b1, validB = 1'b0;
    logic [W-1:0] dataB = '0;
    logic         readyB, busyB, freqB, fenB;

    int tests_run = 0;
    int fails = 0;

    logic [W-1:0] expA[$], expB[$], rxA[$], rxB[$];

    always #5 clk = ~clk;

    speed_tx #(.WIDTH(W), .HALF_PERIOD(H), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(enA), .tx_data(dataA), .tx_valid(validA),
        .tx_ready(readyA), .busy(busyA), .freq(freqA), .f_en(fenA));

    speed_tx #(.WIDTH(W), .HALF_PERIOD(H), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(enB), .tx_data(dataB), .tx_valid(validB),
        .tx_ready(readyB), .busy(busyB), .freq(freqB), .f_en(fenB));

    // Receiver models: shift freq in on each observed f_en rise, emit after W bits.
    logic [W-1:0] bufA = '0, bufB = '0;
    int           rbitA = 0, rbitB = 0;
    logic         prevA = 1'b0, prevB = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rbitA <= 0; prevA <= 1'b0;
        end else begin
            if (fenA && !prevA) begin
                bufA <= {bufA[W-2:0], freqA};
                if (rbitA == W - 1) begin
                    rxA.push_back({bufA[W-2:0], freqA});
                    rbitA <= 0;
                end else rbitA <= rbitA + 1;
            end
            prevA <= fenA;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rbitB <= 0; prevB <= 1'b0;
        end else begin
            if (fenB && !prevB) begin
                bufB <= {bufB[W-2:0], freqB};
                if (rbitB == W - 1) begin
                    rxB.push_back({bufB[W-2:0], freqB});
                    rbitB <= 0;
                end else rbitB <= rbitB + 1;
            end
            prevB <= fenB;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({freqA, fenA, busyA} !== 3'b000) begin
            fails++; $display("FAIL reset_outputs: got %b required 000", {freqA, fenA, busyA});
        end
        tests_run++;
        if ({freqB, fenB, busyB} !== 3'b000) begin
            fails++; $display("FAIL reset_outputs_b: got %b required 000", {freqB, fenB, busyB});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (readyA !== 1'b1 || readyB !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b%b required 11", readyA, readyB);
        end
    endtask

    task automatic test_single();
        int rise_cyc[$];
        logic rise_bit[$];
        logic prev;
        int rdy;
        logic [W-1:0] d;
        d = 4'hB; prev = 1'b0; rdy = 0;
        @(negedge clk);
        validA = 1'b1; dataA = d; expA.push_back(d);
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                validA = 1'b0;
                tests_run++;
                if (busyA !== 1'b1 || readyA !== 1'b0) begin
                    fails++; $display("FAIL single_busy: busy=%b ready=%b required 1 0", busyA, readyA);
                end
            end
            if (fenA && !prev) begin rise_cyc.push_back(n); rise_bit.push_back(freqA); end
            prev = fenA;
            if (readyA && rdy == 0) rdy = n;
        end
        tests_run++;
        if (rise_cyc.size() != W) begin
            fails++; $display("FAIL single_rises: got %0d required %0d", rise_cyc.size(), W);
        end
        for (int k = 0; k < W && k < rise_cyc.size(); k++) begin
            tests_run++;
            if (rise_cyc[k] != 1 + (2*k + 1)*H || rise_bit[k] !== d[W-1-k]) begin
                fails++;
                $display("FAIL single_bit%0d: cycle %0d freq %b required cycle %0d freq %b",
                         k, rise_cyc[k], rise_bit[k], 1 + (2*k + 1)*H, d[W-1-k]);
            end
        end
        tests_run++;
        if (rdy != 1 + 2*H*W + G) begin
            fails++; $display("FAIL single_ready: got cycle %0d required %0d", rdy, 1 + 2*H*W + G);
        end
        tests_run++;
        if (rxA.size() == 0 || expA.size() == 0) begin
            fails++; $display("FAIL single_rx: got %0d words required 1", rxA.size());
        end else if (rxA[0] !== expA[0]) begin
            fails++; $display("FAIL single_rx: got %h required %h", rxA[0], expA[0]);
        end
        rxA.delete(); expA.delete();
    endtask

    task automatic test_back_to_back();
        int rise_cyc[$];
        logic rise_bit[$];
        logic prev;
        logic [W-1:0] d[2];
        d[0] = 4'h5; d[1] = 4'hA; prev = 1'b0;
        @(negedge clk);
        validB = 1'b1; dataB = d[0]; expB.push_back(d[0]); expB.push_back(d[1]);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) dataB = d[1];
            if (n == 17) begin
                tests_run++;
                if (readyB !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready17: got %b required 1", readyB);
                end
            end
            if (fenB && !prev) begin rise_cyc.push_back(n); rise_bit.push_back(freqB); end
            prev = fenB;
            if (n == 18) validB = 1'b0;
        end
        tests_run++;
        if (rise_cyc.size() != 2*W) begin
            fails++; $display("FAIL b2b_rises: got %0d required %0d", rise_cyc.size(), 2*W);
        end
        for (int k = 0; k < 2*W && k < rise_cyc.size(); k++) begin
            tests_run++;
            if (rise_cyc[k] != (k / W)*(2*H*W + 1) + 1 + (2*(k % W) + 1)*H ||
                rise_bit[k] !== d[k / W][W-1-(k % W)]) begin
                fails++;
                $display("FAIL b2b_bit%0d: cycle %0d freq %b required cycle %0d freq %b", k,
                         rise_cyc[k], rise_bit[k], (k / W)*(2*H*W + 1) + 1 + (2*(k % W) + 1)*H,
                         d[k / W][W-1-(k % W)]);
            end
        end
        for (int f = 0; f < 2; f++) begin
            tests_run++;
            if (rxB.size() == 0 || expB.size() == 0) begin
                fails++; $display("FAIL b2b_rx%0d: got no word required one", f);
            end else begin
                if (rxB[0] !== expB[0]) begin
                    fails++; $display("FAIL b2b_rx%0d: got %h required %h", f, rxB[0], expB[0]);
                end
                void'(rxB.pop_front()); void'(expB.pop_front());
            end
        end
        rxB.delete(); expB.delete();
    endtask

    task automatic test_en_freeze();
        int hi_len[$];
        logic prev;
        int rdy;
        int req_len[4];
        req_len = '{2, 9, 2, 2};
        prev = 1'b0; rdy = 0;
        @(negedge clk);
        validA = 1'b1; dataA = 4'h6; expA.push_back(4'h6);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) validA = 1'b0;
            if (fenA && !prev) hi_len.push_back(0);
            if (fenA && hi_len.size() > 0) hi_len[hi_len.size()-1]++;
            prev = fenA;
            if (readyA && rdy == 0) rdy = n;
            if (n == 7) enA = 1'b0;
            if (n == 14) enA = 1'b1;
        end
        tests_run++;
        if (hi_len.size() != W) begin
            fails++; $display("FAIL freeze_rises: got %0d required %0d", hi_len.size(), W);
        end
        for (int k = 0; k < W && k < hi_len.size(); k++) begin
            tests_run++;
            if (hi_len[k] != req_len[k]) begin
                fails++; $display("FAIL freeze_len%0d: got %0d required %0d", k, hi_len[k], req_len[k]);
            end
        end
        tests_run++;
        if (rdy != 1 + 2*H*W + G + 7) begin
            fails++; $display("FAIL freeze_ready: got cycle %0d required %0d", rdy, 1 + 2*H*W + G + 7);
        end
        tests_run++;
        if (rxA.size() == 0 || expA.size() == 0) begin
            fails++; $display("FAIL freeze_rx: got %0d words required 1", rxA.size());
        end else if (rxA[0] !== expA[0]) begin
            fails++; $display("FAIL freeze_rx: got %h required %h", rxA[0], expA[0]);
        end
        rxA.delete(); expA.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        validA = 1'b1; dataA = 4'h9;
        @(posedge clk);
        @(negedge clk);
        validA = 1'b0;
        tests_run++;
        if (freqA !== 1'b1 || fenA !== 1'b0) begin
            fails++; $display("FAIL rstmid_setup: freq=%b f_en=%b required 1 0", freqA, fenA);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({freqA, fenA, busyA} !== 3'b000) begin
            fails++; $display("FAIL rstmid_async: got %b required 000", {freqA, fenA, busyA});
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        tests_run++;
        if (readyA !== 1'b1 || busyA !== 1'b0) begin
            fails++; $display("FAIL rstmid_release: ready=%b busy=%b required 1 0", readyA, busyA);
        end
        @(negedge clk);
        tests_run++;
        if (readyA !== 1'b1 || fenA !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle: ready=%b f_en=%b required 1 0", readyA, fenA);
        end
        rxA.delete(); expA.delete();
    endtask

    task automatic test_busy_reject();
        int bad;
        int rises;
        logic prev;
        int rdy;
        bad = 0; rises = 0; prev = 1'b0; rdy = 0;
        @(negedge clk);
        validA = 1'b1; dataA = 4'h3; expA.push_back(4'h3);
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) validA = 1'b0;
            if (n > 4 && n < 18 && (readyA !== 1'b0 || busyA !== 1'b1)) bad++;
            if (fenA && !prev) rises++;
            prev = fenA;
            if (readyA && rdy == 0) rdy = n;
            if (n == 4) begin validA = 1'b1; dataA = 4'hF; end
            if (n == 18) validA = 1'b0;
        end
        tests_run++;
        if (bad != 0) begin
            fails++; $display("FAIL reject_ready: got %0d cycles with ready/busy wrong required 0", bad);
        end
        tests_run++;
        if (rises != W || rdy != 1 + 2*H*W + G) begin
            fails++; $display("FAIL reject_frame: rises %0d ready cycle %0d required %0d %0d",
                              rises, rdy, W, 1 + 2*H*W + G);
        end
        tests_run++;
        if (rxA.size() != 1 || expA.size() != 1) begin
            fails++; $display("FAIL reject_rx: got %0d words required 1", rxA.size());
        end else if (rxA[0] !== expA[0]) begin
            fails++; $display("FAIL reject_rx: got %h required %h", rxA[0], expA[0]);
        end
        rxA.delete(); expA.delete();
    endtask

    task automatic test_en_idle();
        int bad;
        bad = 0;
        @(negedge clk);
        enA = 1'b0; validA = 1'b1; dataA = 4'hF;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (readyA !== 1'b0 || fenA !== 1'b0 || busyA !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++; $display("FAIL en_idle: got %0d active cycles required 0", bad);
        end
        validA = 1'b0;
        enA = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rxA.size() != 0 || readyA !== 1'b1) begin
            fails++; $display("FAIL en_idle_after: words %0d ready %b required 0 1", rxA.size(), readyA);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_en_freeze();
        test_reset_mid();
        test_busy_reject();
        test_en_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
